mmio_hub: RTL and testbench

- Parametrised memory-mapped I/O hub sitting between the processor data-memory port and on-board peripherals.
- Replaces the fixed 4-way MMIO read mux with a base-aligned, slot-decoded register window.
- Adds writable registers, read side effects, and a buffered MIDI event FIFO so bursts of MIDI messages are not lost between processor polls.

---
 rtl/mmio_hub.sv | 217 +++++++++++++++++++++
 tb/tb_mmio_hub.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O hub between the processor data port and peripherals.
// Base-aligned window of 2**SLOT_BITS word slots with ID, RNG, MIDI event FIFO,
// status, seven-segment and LED registers.
// Optional feature: define MMIO_TIMER_EN to build a free-running 32-bit cycle
// counter in slot 6; without it slot 6 behaves like an unmapped slot.
module mmio_hub #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h2000,
    parameter int unsigned           SLOT_BITS       = 3,
    parameter int unsigned           FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0]           DEFAULT_DATA    = 32'hfbadc0de
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic                   mem_ren,
    input  logic                   wren,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   mmio_hit,
    input  logic [31:0]            rng_data,
    output logic                   rng_next,
    input  logic [23:0]            midi_bytes,
    input  logic                   midi_busy,
    output logic [31:0]            sevenseg_word,
    output logic [15:0]            led_word,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CW         = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned PW         = FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [31:0] ID_WORD = 32'(BASE_ADDR);

    localparam logic [SLOT_BITS-1:0] SLOT_ID     = SLOT_BITS'(0);
    localparam logic [SLOT_BITS-1:0] SLOT_RNG    = SLOT_BITS'(1);
    localparam logic [SLOT_BITS-1:0] SLOT_FIFO   = SLOT_BITS'(2);
    localparam logic [SLOT_BITS-1:0] SLOT_STATUS = SLOT_BITS'(3);
    localparam logic [SLOT_BITS-1:0] SLOT_SEG    = SLOT_BITS'(4);
    localparam logic [SLOT_BITS-1:0] SLOT_LED    = SLOT_BITS'(5);
`ifdef MMIO_TIMER_EN
    localparam logic [SLOT_BITS-1:0] SLOT_TIMER  = SLOT_BITS'(6);
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [SLOT_BITS-1:0] slot;
    logic                 rd_fire;
    logic                 wr_fire;

    assign slot     = address[SLOT_BITS-1:0];
    assign mmio_hit = (address[ADDR_WIDTH-1:SLOT_BITS] == BASE_ADDR[ADDR_WIDTH-1:SLOT_BITS]);
    assign rd_fire  = mmio_hit & mem_ren;
    assign wr_fire  = mmio_hit & wren;
    assign rng_next = rd_fire & (slot == SLOT_RNG);

    // ------------------------------------------------------------------
    // MIDI busy synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic busy_s1_q;
    logic busy_s2_q;
    logic busy_prev_q;
    logic push_req;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_s1_q   <= 1'b0;
            busy_s2_q   <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            busy_s1_q   <= midi_busy;
            busy_s2_q   <= busy_s1_q;
            busy_prev_q <= busy_s2_q;
        end
    end

    assign push_req = busy_prev_q & ~busy_s2_q;

    // ------------------------------------------------------------------
    // MIDI event FIFO
    // ------------------------------------------------------------------
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic          overflow_set;
    logic          overflow_clr;
    logic [31:0]   head_word;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNT_FULL);
    assign pop          = rd_fire & (slot == SLOT_FIFO) & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok      = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;
    assign overflow_clr = wr_fire & (slot == SLOT_STATUS);
    assign head_word    = fifo_empty ? 32'h0 : {8'h00, fifo_mem[rd_ptr_q]};
    assign fifo_count   = count_q;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage array; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= midi_bytes;
        end
    end

    // Pointers, occupancy and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output latches
    // ------------------------------------------------------------------
    logic [31:0] sevenseg_q;
    logic [15:0] led_q;

    // Seven-segment and LED registers written by stores to their slots.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sevenseg_q <= 32'h0;
            led_q      <= 16'h0;
        end else begin
            if (wr_fire && (slot == SLOT_SEG)) begin
                sevenseg_q <= wdata;
            end
            if (wr_fire && (slot == SLOT_LED)) begin
                led_q <= wdata[15:0];
            end
        end
    end

    assign sevenseg_word = sevenseg_q;
    assign led_word      = led_q;

`ifdef MMIO_TIMER_EN
    // ------------------------------------------------------------------
    // Free-running cycle counter
    // ------------------------------------------------------------------
    logic [31:0] timer_q;

    // Counts every clock; a store reloads it and counting resumes next cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else if (wr_fire && (slot == SLOT_TIMER)) begin
            timer_q <= wdata;
        end else begin
            timer_q <= timer_q + 32'h1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational load data; misses and unmapped slots return DEFAULT_DATA.
    always_comb begin
        rdata = DEFAULT_DATA;
        if (mmio_hit) begin
            case (slot)
                SLOT_ID:     rdata = ID_WORD;
                SLOT_RNG:    rdata = rng_data;
                SLOT_FIFO:   rdata = head_word;
                SLOT_STATUS: rdata = {overflow_q, 15'h0, 16'(count_q)};
                SLOT_SEG:    rdata = sevenseg_q;
                SLOT_LED:    rdata = {16'h0, led_q};
`ifdef MMIO_TIMER_EN
                SLOT_TIMER:  rdata = timer_q;
`endif
                default:     rdata = DEFAULT_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Directed self-checking bench for mmio_hub (default parameters, depth 16).
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_mmio_hub;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] address = 32'h0;
    logic        mem_ren = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        mmio_hit;
    logic [31:0] rng_data = 32'h0;
    logic        rng_next;
    logic [23:0] midi_bytes = 24'h0;
    logic        midi_busy = 1'b0;
    logic [31:0] sevenseg_word;
    logic [15:0] led_word;
    logic [4:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_hub dut (
        .clock         (clock),
        .resetn        (resetn),
        .address       (address),
        .mem_ren       (mem_ren),
        .wren          (wren),
        .wdata         (wdata),
        .rdata         (rdata),
        .mmio_hit      (mmio_hit),
        .rng_data      (rng_data),
        .rng_next      (rng_next),
        .midi_bytes    (midi_bytes),
        .midi_busy     (midi_busy),
        .sevenseg_word (sevenseg_word),
        .led_word      (led_word),
        .fifo_count    (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one full clock and return just after the falling edge.
    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        address = addr;
        mem_ren = 1'b1;
        #1;
        check(tag, rdata, exp);
        cycle();
        mem_ren = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        address = addr;
        wdata   = data;
        wren    = 1'b1;
        cycle();
        wren = 1'b0;
    endtask

    // One MIDI message: busy high long enough to settle, then fall; the push
    // lands on the third rising edge after the fall.
    task automatic midi_msg(input logic [23:0] bytes);
        midi_bytes = bytes;
        midi_busy  = 1'b1;
        repeat (3) cycle();
        midi_busy = 1'b0;
        repeat (4) cycle();
    endtask

    logic [31:0] exp_word;

    initial begin
        // Reset state
        repeat (2) cycle();
        #1;
        check("rst_sevenseg", sevenseg_word, 32'h0);
        check("rst_led", {16'h0, led_word}, 32'h0);
        check("rst_count", {27'h0, fifo_count}, 32'h0);
        resetn = 1'b1;
        cycle();

        // Decode
        address = 32'h2000; #1;
        check("hit_2000", {31'h0, mmio_hit}, 32'h1);
        do_load(32'h2000, 32'h00002000, "id");
        address = 32'h2007; #1;
        check("hit_2007", {31'h0, mmio_hit}, 32'h1);
        do_load(32'h2007, 32'hfbadc0de, "slot7");
        address = 32'h1fff; #1;
        check("hit_1fff", {31'h0, mmio_hit}, 32'h0);
        do_load(32'h1fff, 32'hfbadc0de, "miss");

        // RNG slot and pulse
        rng_data = 32'hdeadbeef;
        address  = 32'h2001;
        mem_ren  = 1'b1;
        #1;
        check("rng_data", rdata, 32'hdeadbeef);
        check("rng_next_on", {31'h0, rng_next}, 32'h1);
        cycle();
        mem_ren = 1'b0;
        #1;
        check("rng_next_off", {31'h0, rng_next}, 32'h0);

        // Writable latches
        do_store(32'h2004, 32'h12345678);
        do_store(32'h2005, 32'h0000abcd);
        do_store(32'h2000, 32'hffffffff);
        #1;
        check("sevenseg", sevenseg_word, 32'h12345678);
        check("led", {16'h0, led_word}, 32'h0000abcd);
        do_load(32'h2004, 32'h12345678, "rd_seg");
        do_load(32'h2005, 32'h0000abcd, "rd_led");
        do_load(32'h2000, 32'h00002000, "id_after_wr");

        // MIDI capture latency: count rises on the third edge after the fall
        midi_bytes = 24'h903c40;
        midi_busy  = 1'b1;
        repeat (3) cycle();
        midi_busy = 1'b0;
        repeat (2) cycle();
        #1;
        check("midi_lat2", {27'h0, fifo_count}, 32'h0);
        cycle();
        #1;
        check("midi_lat3", {27'h0, fifo_count}, 32'h1);
        cycle();
        midi_msg(24'h803c00);
        midi_msg(24'hb00101);
        #1;
        check("count3", {27'h0, fifo_count}, 32'h3);
        do_load(32'h2003, 32'h00000003, "status3");
        do_load(32'h2002, 32'h00903c40, "pop0");
        do_load(32'h2002, 32'h00803c00, "pop1");
        do_load(32'h2002, 32'h00b00101, "pop2");
        do_load(32'h2002, 32'h00000000, "pop_empty");
        #1;
        check("count0", {27'h0, fifo_count}, 32'h0);

        // Overflow: 17 pushes into 16 entries
        for (int i = 1; i <= 17; i++) begin
            midi_msg(24'h000100 + 24'(i));
        end
        #1;
        check("count_full", {27'h0, fifo_count}, 32'h10);
        do_load(32'h2003, 32'h80000010, "status_ovf");
        do_store(32'h2003, 32'h0);
        do_load(32'h2003, 32'h00000010, "status_clr");

        // Full FIFO: pop in the same cycle as a push
        midi_bytes = 24'haaaaaa;
        midi_busy  = 1'b1;
        repeat (3) cycle();
        midi_busy = 1'b0;
        repeat (2) cycle();
        do_load(32'h2002, 32'h00000101, "sim_pop");
        #1;
        check("sim_count", {27'h0, fifo_count}, 32'h10);
        do_load(32'h2003, 32'h00000010, "sim_status");
        cycle();

        // Drain: 0x102..0x110 then the new entry; 0x111 was dropped
        for (int i = 2; i <= 16; i++) begin
            exp_word = 32'h00000100 + 32'(i);
            do_load(32'h2002, exp_word, "drain");
        end
        do_load(32'h2002, 32'h00aaaaaa, "drain_last");
        do_load(32'h2002, 32'h00000000, "drain_empty");

        // Reset mid-burst discards contents
        midi_msg(24'h123456);
        midi_msg(24'h654321);
        #1;
        check("pre_rst_count", {27'h0, fifo_count}, 32'h2);
        resetn = 1'b0;
        #1;
        check("rst_async_count", {27'h0, fifo_count}, 32'h0);
        check("rst_async_seg", sevenseg_word, 32'h0);
        cycle();
        resetn = 1'b1;
        cycle();
        do_load(32'h2002, 32'h00000000, "rst_fifo_empty");

        // Timer slot
        do_store(32'h2006, 32'hfffffffe);
        repeat (2) cycle();
`ifdef MMIO_TIMER_EN
        do_load(32'h2006, 32'h00000000, "timer_wrap");
`else
        do_load(32'h2006, 32'hfbadc0de, "timer_absent");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
